// File: rtl/wave_pkg.sv
// Shared state encoding and default sizing for the waveform frame reader.
package wave_pkg;
   localparam int DEF_NUM_POINTS = 300;
   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DATA_W     = 8;

   typedef enum logic [2:0] {IDLE, REFRESH, WAIT, READ, DRAIN, DONE} wave_state_e;
endpackage

// File: rtl/wave_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; any depth >= 1.
module wave_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full, do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (!full || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= nxt(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= nxt(rd_ptr_q);
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // Read credits guarantee a free slot for every returning sample.
   ovf_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !pop_i));
endmodule

// File: rtl/wave_frame_reader.sv
// Reads the capture display buffer and streams it as a framed byte stream.
// WAVE_FRAME_CKSUM_EN appends a two's-complement checksum beat carrying m_eof.
module wave_frame_reader
   import wave_pkg::*;
#(
   parameter int NUM_POINTS   = DEF_NUM_POINTS,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int RD_LAT       = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int REFRESH_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_req,
   output logic              busy,
   output logic              ram_refresh,
   output logic [ADDR_W-1:0] wave_rd_addr,
   input  logic [DATA_W-1:0] wave_rd_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sof,
   output logic              m_eof,
   output logic              frame_done
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int WW = (REFRESH_WAIT > 1) ? $clog2(REFRESH_WAIT) : 1;
   localparam int FW = DATA_W + 2;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_POINTS - 1);

   wave_state_e       state_q, state_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] push_idx_q;
   logic [RD_LAT-1:0] vld_pipe_q;
   logic              issue, push, pop, eof_xfer, fifo_empty;
   logic [FW-1:0]     fifo_dout;
   logic [CW-1:0]     fifo_count;
   int                inflight;

   always_comb begin
      inflight = 0;
      for (int i = 0; i < RD_LAT; i++) inflight += int'(vld_pipe_q[i]);
   end

   assign issue = (state_q == READ) && (inflight + int'(fifo_count) < FIFO_DEPTH);
   assign push  = vld_pipe_q[RD_LAT-1];
   assign pop   = m_ready && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         addr_q     <= '0;
         vld_pipe_q <= '0;
         push_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         addr_q     <= addr_d;
         vld_pipe_q <= RD_LAT'({vld_pipe_q, issue});
         if (state_q == REFRESH) push_idx_q <= '0;
         else if (push)          push_idx_q <= push_idx_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE:    if (frame_req) state_d = REFRESH;
         REFRESH: begin
            wait_d  = '0;
            state_d = WAIT;
         end
         WAIT:    if (wait_q == WW'(REFRESH_WAIT - 1)) state_d = READ;
                  else wait_d = wait_q + 1'b1;
         READ:    if (issue) begin
            if (addr_q == LAST) state_d = DRAIN;
            else                addr_d  = addr_q + 1'b1;
         end
         DRAIN:   if (eof_xfer) state_d = DONE;
         DONE:    begin
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != IDLE);
      ram_refresh = (state_q == REFRESH);
      frame_done  = (state_q == DONE);
   end

   assign wave_rd_addr = addr_q;

   // FIFO entry: {sof, last_sample, data}
   wave_sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .din_i   ({push_idx_q == '0, push_idx_q == LAST, wave_rd_data}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef WAVE_FRAME_CKSUM_EN
   logic [7:0] sum_q;
   logic       cks_pend_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q      <= '0;
         cks_pend_q <= 1'b0;
      end else begin
         if (pop) sum_q <= fifo_dout[FW-1] ? 8'(fifo_dout[DATA_W-1:0])
                                           : sum_q + 8'(fifo_dout[DATA_W-1:0]);
         if (pop && fifo_dout[FW-2])                  cks_pend_q <= 1'b1;
         else if (cks_pend_q && fifo_empty && m_ready) cks_pend_q <= 1'b0;
      end
   end

   // The last sample is the final FIFO entry, so the checksum beat follows once it drains.
   always_comb begin
      m_valid = !fifo_empty || cks_pend_q;
      m_data  = '0;
      m_sof   = 1'b0;
      m_eof   = 1'b0;
      if (!fifo_empty) begin
         m_data = fifo_dout[DATA_W-1:0];
         m_sof  = fifo_dout[FW-1];
      end else if (cks_pend_q) begin
         m_data = DATA_W'(~sum_q + 8'd1);
         m_eof  = 1'b1;
      end
   end
`else
   always_comb begin
      m_valid = !fifo_empty;
      m_data  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
      m_sof   = !fifo_empty && fifo_dout[FW-1];
      m_eof   = !fifo_empty && fifo_dout[FW-2];
   end
`endif

   assign eof_xfer = m_valid && m_ready && m_eof;
endmodule

// File: doc/wave_frame_reader.md
Name: wave_frame_reader

Overview:
- Downstream consumer of the DSO capture store. On request, pulses ram_refresh, reads the NUM_POINTS-sample display buffer through its address/data read port, and emits the samples as a framed byte stream with valid/ready handshake.
- Sits in the RAM read-clock domain, between the capture store and the host/display frame packer.
- Absorbs the RAM read latency and downstream backpressure with a credit-controlled output FIFO.

Parameters:
- NUM_POINTS, 300, samples per frame; addresses 0..NUM_POINTS-1.
- ADDR_W, 10, wave_rd_addr width.
- DATA_W, 8, sample width.
- RD_LAT, 1, cycles from wave_rd_addr to valid wave_rd_data; legal range 1..3.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1.
- REFRESH_WAIT, 4, idle cycles after the ram_refresh pulse before the first read.

Ports:
- clk  in  1  RAM read clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_req  in  1  single-cycle start request.
- busy  out  1  high from accepted request until frame_done.
- ram_refresh  out  1  one-cycle pulse to the capture store.
- wave_rd_addr  out  ADDR_W  read address.
- wave_rd_data  in  DATA_W  read data, valid RD_LAT cycles after its address.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_sof  out  1  qualifies the first beat of a frame.
- m_eof  out  1  qualifies the last beat of a frame.
- frame_done  out  1  one-cycle pulse after the eof beat transfers.

Behaviour:
- Reset values: busy=0, ram_refresh=0, wave_rd_addr=0, m_valid=0, m_sof=0, m_eof=0, frame_done=0, m_data=0. The FIFO, credit counter and read pipeline are cleared.
- FSM states:
  - IDLE: frame_req -> REFRESH.
  - REFRESH: ram_refresh=1 for exactly one cycle -> WAIT.
  - WAIT: count REFRESH_WAIT cycles -> READ.
  - READ: issue addresses -> DRAIN after issuing address NUM_POINTS-1.
  - DRAIN: wait for the FIFO to empty and the eof beat to transfer -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- frame_req while busy is ignored and not queued.
- Read issue in READ: an address is issued in a cycle only when (inflight + fifo_count) < FIFO_DEPTH.
  - inflight counts reads issued but not yet returned; fifo_count is the current FIFO occupancy.
  - wave_rd_addr increments by 1 per issued read, from 0 to NUM_POINTS-1; it returns to 0 in DONE.
  - wave_rd_addr holds when no read is issued.
- Read return: a shift-register valid pipeline of depth RD_LAT captures wave_rd_data into the FIFO. The FIFO cannot overflow by construction; an overflow is an assertion failure.
- Stream output:
  - m_valid = FIFO not empty; m_data = FIFO head (first-word-fall-through).
  - A beat transfers on m_valid && m_ready.
  - m_data, m_sof and m_eof stay stable while m_valid && !m_ready.
  - m_sof is set on the beat of sample index 0; m_eof on the beat of index NUM_POINTS-1 (or on the checksum beat when that feature is compiled in).
- Throughput: with m_ready held high, one beat per cycle. First beat appears REFRESH_WAIT+RD_LAT+3 cycles after frame_req.
- Simultaneous FIFO push and pop in one cycle: count unchanged.
- fifo_count == FIFO_DEPTH: no issue. fifo_count == 0: m_valid=0.
- rst asserted mid-frame: abort immediately; all outputs return to reset values next cycle; no frame_done.

Optional Feature:
- Macro WAVE_FRAME_CKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all transferred samples is kept and reset at sof.
  - After sample NUM_POINTS-1, one extra beat carries the two's complement of the sum (so the sum of all beats is 0 mod 256).
  - m_eof moves to the checksum beat; frames are NUM_POINTS+1 beats.
  - Requires DATA_W=8.
- Undefined: frames are NUM_POINTS beats, m_eof on the last sample, and the checksum logic is absent.

Decomposition:
- Package wave_pkg:
  - FSM state enum (IDLE, REFRESH, WAIT, READ, DRAIN, DONE).
  - Default constants NUM_POINTS=300, ADDR_W=10, DATA_W=8.
- One natural sub-module: wave_sync_fifo, a parameterised synchronous first-word-fall-through FIFO with count output, instantiated once for the output buffer.

Test Plan:
- Basic frame, m_ready=1, RAM model returns data=addr[7:0] (RD_LAT=1): frame_req -> one ram_refresh pulse, 300 beats 0,1,..,255,0,..,43. m_sof on beat 0, m_eof on beat 299, frame_done one cycle after, busy low.
- Backpressure: m_ready toggles 1/0 each cycle, plus 20-cycle stall at beat 100 -> no lost or duplicated samples, data stable during stalls, wave_rd_addr never more than FIFO_DEPTH ahead of the transferred count.
- RD_LAT=3, FIFO_DEPTH=4, m_ready=1 -> identical 300-beat sequence; no FIFO overflow assertion.
- frame_req re-pulsed at beat 50 -> ignored; exactly one frame, one ram_refresh, one frame_done.
- rst asserted at beat 150 -> next cycle m_valid=0, busy=0, wave_rd_addr=0; a new frame_req yields a complete frame starting at sample 0.
- WAVE_FRAME_CKSUM_EN with constant data 0x01 -> 301 beats, checksum beat 0xD4 (-300 mod 256), m_eof on beat 300.
